clk_div_seq: RTL and testbench
==============================

Name: clk_div_seq

Overview:
- Parametrised multi-channel clock divider with a power-on init sequencer; successor to the single fixed-ratio I2C clock divider.
- Each channel produces a 50%-duty divided clock plus single-cycle rise/fall strobes.
- Each channel's divisor is runtime-loadable, glitch-free.
- Sits between the 24 MHz system clock and the serial peripherals (I2C, SPI, LED PWM). Also owns the global init reset hold-off.

Parameters:
CHANNELS, 2, number of independent divider channels
CNT_W, 8, width of the per-channel half-period counter and divisor
DEFAULT_HALF, 14, reset half-period value (14 at 24 MHz gives an 800 kHz I2C clock)
INIT_DELAY, 16, clk cycles that init_rst is held after reset release (0 allowed)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous active-high reset
div_half  in  CHANNELS*CNT_W  per-channel half-period minus 1; channel i uses bits [i*CNT_W +: CNT_W]
div_load  in  CHANNELS  1-cycle strobe; captures div_half for channel i
ch_en  in  CHANNELS  channel run enable, level-sensitive
div_clk  out  CHANNELS  divided clock, registered
rise_tick  out  CHANNELS  high for one clk cycle when div_clk[i] goes 0->1
fall_tick  out  CHANNELS  high for one clk cycle when div_clk[i] goes 1->0
init_rst  out  1  global peripheral reset, high during init
ready  out  1  high once init is complete

Behaviour:
- Reset values (rst=1 at a clk edge):
  - Outputs: div_clk=0, rise_tick=0, fall_tick=0, init_rst=1, ready=0.
  - Internal: state=INIT, init counter=INIT_DELAY, all channel counters=0, active half=pending half=DEFAULT_HALF, pending flag=0.
- Reset mid-operation: same values on the next edge. Any in-flight period is abandoned with no fall_tick, and INIT restarts.
- Sequencer states: INIT, RUN.
  - INIT: init_rst=1, ready=0. Decrement once per clk. When the counter is 0, move to RUN: init_rst<=0 and ready<=1 on the same edge.
  - Timing: init_rst falls exactly INIT_DELAY+1 edges after the first edge with rst=0.
  - RUN: terminal until rst.
- Channel counting: channels are frozen (counter 0, div_clk 0, no ticks) while state != RUN or ch_en[i]=0.
- Per enabled channel in RUN:
  - Counter increments each clk.
  - When counter==active half: counter<=0 and div_clk toggles.
  - The matching tick is registered high for exactly the first cycle div_clk shows the new level.
  - Period = 2*(half+1) clk cycles; duty exactly 50%.
  - half=0 gives divide-by-2: ticks alternate rise/fall every cycle.
- First edge: after the first RUN cycle (or the ch_en rising cycle), the first rise_tick occurs half+1 cycles later.
- Divisor load:
  - div_load[i] copies div_half slice into pending and sets the pending flag.
  - Pending is transferred to active only at a period boundary (the edge producing fall_tick), so no short or long half-periods occur mid-period.
  - If the channel is frozen (disabled or INIT), the transfer happens on the next edge.
  - div_load coinciding with a boundary edge: the newly loaded value is applied at that boundary (bypass).
  - Multiple loads before a boundary: the last one wins.
- Disable mid-period (ch_en falls): next edge counter<=0, div_clk<=0, no fall_tick, pending is kept. Re-enable restarts from phase 0.
- Channels are fully independent. Identical settings enabled on the same cycle stay phase-locked indefinitely.
- Width rule: counter compare is unsigned CNT_W. Maximum period = 2^(CNT_W+1) clk cycles. No overflow is possible because the counter never exceeds active half.

Test Plan:
- Reset/init (INIT_DELAY=16): rst high 3 cycles then low -> init_rst stays 1 for exactly 17 edges, then init_rst=0 and ready=1 together; div_clk=0 throughout INIT.
- Default divide (DEFAULT_HALF=14, ch_en=all 1) -> div_clk period 30 cycles, 15 high/15 low; first rise_tick 15 cycles after ready; ticks one cycle wide and coincident with the div_clk level change.
- Runtime reload: mid-high-phase, load half=4 on ch0 -> current period completes at 30 cycles, then period 10; ch1 remains at 30, unaffected. A second load of half=2 before the boundary replaces 4.
- Edge cases: half=0 -> div_clk toggles every cycle, period 2. half=255 (CNT_W=8) -> period 512. div_load on the boundary cycle -> new value used for the immediately following half-period.
- Disable/re-enable: drop ch_en[0] while div_clk=1 -> next cycle div_clk=0 with no fall_tick. Re-assert -> rise after half+1 cycles.
- Mid-run rst pulse of 1 cycle -> all outputs return to reset values next edge, init_rst=1, and the INIT_DELAY sequence repeats.

Source files
------------

// File: rtl/clk_div_seq_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master side configures the channels; the slave side is the divider itself.
interface clk_div_seq_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  logic [CHANNELS*CNT_W-1:0] div_half;
  logic [CHANNELS-1:0]       div_load;
  logic [CHANNELS-1:0]       ch_en;
  logic [CHANNELS-1:0]       div_clk;
  logic [CHANNELS-1:0]       rise_tick;
  logic [CHANNELS-1:0]       fall_tick;
  logic                      init_rst;
  logic                      ready;

  modport master (
    output div_half, div_load, ch_en,
    input  div_clk, rise_tick, fall_tick, init_rst, ready
  );

  modport slave (
    input  div_half, div_load, ch_en,
    output div_clk, rise_tick, fall_tick, init_rst, ready
  );
endinterface

// File: rtl/clk_div_seq.sv
// Multi-channel 50%-duty clock divider with glitch-free divisor reload,
// plus the power-on sequencer that holds the peripheral reset after rst.
//
// state  | meaning
// S_INIT | init_rst held high, channels frozen, hold-off counter running down
// S_RUN  | init done, ready high, enabled channels divide (terminal until rst)
module clk_div_seq #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 14,
  parameter int INIT_DELAY   = 16
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_seq_if.slave  bus
);

  localparam int INIT_W = (INIT_DELAY > 0) ? $clog2(INIT_DELAY + 1) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic                init_rst_q;
  logic                ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_cnt   <= INIT_W'(INIT_DELAY);
      init_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else if (state == S_INIT) begin
      if (init_cnt == '0) begin
        state      <= S_RUN;
        init_rst_q <= 1'b0;
        ready_q    <= 1'b1;
      end else begin
        init_cnt <= init_cnt - INIT_W'(1);
      end
    end
  end

  assign bus.init_rst = init_rst_q;
  assign bus.ready    = ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_act;
    logic [CNT_W-1:0] half_pend;
    logic [CNT_W-1:0] half_in;
    logic             pend;
    logic             dclk;
    logic             rtick;
    logic             ftick;
    logic             frozen;
    logic             hit;

    assign half_in = bus.div_half[i*CNT_W +: CNT_W];
    assign frozen  = (state != S_RUN) || !bus.ch_en[i];
    assign hit     = (cnt == half_act);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt       <= '0;
        dclk      <= 1'b0;
        rtick     <= 1'b0;
        ftick     <= 1'b0;
        half_act  <= CNT_W'(DEFAULT_HALF);
        half_pend <= CNT_W'(DEFAULT_HALF);
        pend      <= 1'b0;
      end else begin
        if (bus.div_load[i]) begin
          half_pend <= half_in;
          pend      <= 1'b1;
        end
        if (frozen) begin
          cnt   <= '0;
          dclk  <= 1'b0;
          rtick <= 1'b0;
          ftick <= 1'b0;
          // A load landing on this same edge stays pending for the next one.
          if (pend) begin
            half_act <= half_pend;
            if (!bus.div_load[i]) pend <= 1'b0;
          end
        end else begin
          rtick <= hit && !dclk;
          ftick <= hit && dclk;
          if (hit) begin
            cnt  <= '0;
            dclk <= !dclk;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // Period boundary: a load on this very edge bypasses the pending copy.
          if (hit && dclk) begin
            if (bus.div_load[i]) begin
              half_act <= half_in;
              pend     <= 1'b0;
            end else if (pend) begin
              half_act <= half_pend;
              pend     <= 1'b0;
            end
          end
        end
      end
    end

    assign bus.div_clk[i]   = dclk;
    assign bus.rise_tick[i] = rtick;
    assign bus.fall_tick[i] = ftick;
  end

endmodule

// File: tb/tb_clk_div_seq.sv
// Self-checking bench for clk_div_seq: expected tick times are queued per
// channel as stimulus is applied and matched against the DUT's ticks.
module tb_clk_div_seq;
  localparam int CH = 2;
  localparam int CW = 8;

  typedef struct {
    int t;
    bit rise;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   coh_en = 1'b0;
  logic [CH-1:0] prev_clk = '0;
  ev_t  sb0[$];
  ev_t  sb1[$];

  clk_div_seq_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  clk_div_seq #(
    .CHANNELS(CH), .CNT_W(CW), .DEFAULT_HALF(14), .INIT_DELAY(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit sb_has(int ch);
    if (ch == 0) return sb0.size() > 0;
    return sb1.size() > 0;
  endfunction

  function automatic ev_t sb_front(int ch);
    if (ch == 0) return sb0[0];
    return sb1[0];
  endfunction

  function automatic void sb_drop(int ch);
    if (ch == 0) void'(sb0.pop_front());
    else void'(sb1.pop_front());
  endfunction

  task automatic push_edges(int ch, int first, int spacing, int n, bit first_rise);
    ev_t e;
    for (int k = 0; k < n; k++) begin
      e.t    = first + k * spacing;
      e.rise = ((k % 2) == 0) ? first_rise : !first_rise;
      if (ch == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
  endtask

  task automatic goto(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Tick scoreboard and tick/level coherence monitor.
  logic r, f, d, p;
  ev_t  e;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < CH; ch++) begin
        r = bus.rise_tick[ch];
        f = bus.fall_tick[ch];
        d = bus.div_clk[ch];
        p = prev_clk[ch];
        if (coh_en) begin
          n_vec++;
          if ({r, f} !== {d & ~p, ~d & p}) begin
            n_err++;
            $display("FAIL tick_coherence ch%0d cyc %0d: rise/fall=%b%b, required %b%b",
                     ch, cyc, r, f, d & ~p, ~d & p);
          end
        end
        while (sb_has(ch) && sb_front(ch).t < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL missed_tick ch%0d: no tick observed at cycle %0d, required rise=%0b",
                   ch, sb_front(ch).t, sb_front(ch).rise);
          sb_drop(ch);
        end
        if (r || f) begin
          n_vec++;
          if (!sb_has(ch) || sb_front(ch).t != cyc) begin
            n_err++;
            $display("FAIL unexpected_tick ch%0d cyc %0d: rise/fall=%b%b, required none",
                     ch, cyc, r, f);
          end else begin
            e = sb_front(ch);
            if (r !== e.rise || f !== !e.rise) begin
              n_err++;
              $display("FAIL tick_kind ch%0d cyc %0d: rise/fall=%b%b, required rise=%0b",
                       ch, cyc, r, f, e.rise);
            end
            sb_drop(ch);
          end
        end
      end
    end
    prev_clk = bus.div_clk;
  end

  int t_ready;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.div_clk, bus.rise_tick, bus.fall_tick, bus.init_rst, bus.ready} !== 8'b00_00_00_1_0) begin
      n_err++;
      $display("FAIL reset_values: clk/rise/fall/init_rst/ready=%b, required 00000010",
               {bus.div_clk, bus.rise_tick, bus.fall_tick, bus.init_rst, bus.ready});
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.init_rst, bus.ready, bus.div_clk} !== 4'b1000) begin
        n_err++;
        $display("FAIL init_hold edge %0d: init_rst/ready/div_clk=%b, required 1000",
                 k, {bus.init_rst, bus.ready, bus.div_clk});
      end
    end
    @(negedge clk);
    n_vec++;
    if ({bus.init_rst, bus.ready, bus.div_clk} !== 4'b0100) begin
      n_err++;
      $display("FAIL init_release edge 17: init_rst/ready/div_clk=%b, required 0100",
               {bus.init_rst, bus.ready, bus.div_clk});
    end
    t_ready = cyc;
  endtask

  task automatic test_default_divide();
    int t;
    t = t_ready;
    push_edges(0, t + 15, 15, 4, 1'b1);
    push_edges(1, t + 15, 15, 4, 1'b1);
    mon_en = 1'b1;
    coh_en = 1'b1;
    goto(t + 14);
    n_vec++;
    if (bus.div_clk !== 2'b00) begin
      n_err++;
      $display("FAIL default_pre_rise: div_clk=%b, required 00", bus.div_clk);
    end
    goto(t + 15);
    n_vec++;
    if (bus.div_clk !== 2'b11) begin
      n_err++;
      $display("FAIL default_first_rise: div_clk=%b, required 11", bus.div_clk);
    end
    goto(t + 61);
    n_vec++;
    if (sb0.size() + sb1.size() != 0) begin
      n_err++;
      $display("FAIL default_events_left: %0d, required 0", sb0.size() + sb1.size());
    end
  endtask

  task automatic test_reload();
    int t;
    t = t_ready;
    bus.div_half[2*CW-1:CW] = 8'h33;
    push_edges(1, t + 75, 15, 6, 1'b1);
    push_edges(0, t + 75, 15, 2, 1'b1);
    push_edges(0, t + 95, 5, 4, 1'b1);
    push_edges(0, t + 113, 3, 13, 1'b1);
    goto(t + 80);
    bus.div_half[CW-1:0] = 8'd4;
    bus.div_load = 2'b01;
    @(negedge clk);
    bus.div_load = 2'b00;
    goto(t + 106);
    bus.div_half[CW-1:0] = 8'd9;
    bus.div_load = 2'b01;
    @(negedge clk);
    bus.div_load = 2'b00;
    goto(t + 108);
    bus.div_half[CW-1:0] = 8'd2;
    bus.div_load = 2'b01;
    @(negedge clk);
    bus.div_load = 2'b00;
    goto(t + 140);
    n_vec++;
    if (bus.div_clk[1] !== 1'b1) begin
      n_err++;
      $display("FAIL reload_ch1_level: div_clk[1]=%b, required 1", bus.div_clk[1]);
    end
    goto(t + 151);
    n_vec++;
    if (sb0.size() + sb1.size() != 0) begin
      n_err++;
      $display("FAIL reload_events_left: %0d, required 0", sb0.size() + sb1.size());
    end
  endtask

  task automatic test_disable();
    int t;
    t = t_ready;
    n_vec++;
    if (bus.div_clk[0] !== 1'b1) begin
      n_err++;
      $display("FAIL disable_pre_level: div_clk[0]=%b, required 1", bus.div_clk[0]);
    end
    coh_en = 1'b0;
    bus.ch_en = 2'b00;
    @(negedge clk);
    n_vec++;
    if ({bus.div_clk, bus.fall_tick} !== 4'b0000) begin
      n_err++;
      $display("FAIL disable_drop: div_clk/fall_tick=%b, required 0000",
               {bus.div_clk, bus.fall_tick});
    end
    @(negedge clk);
    coh_en = 1'b1;
    bus.ch_en = 2'b01;
    push_edges(0, cyc + 3, 3, 4, 1'b1);
    goto(t + 166);
    bus.ch_en = 2'b00;
    n_vec++;
    if (sb0.size() != 0) begin
      n_err++;
      $display("FAIL reenable_events_left: %0d, required 0", sb0.size());
    end
  endtask

  task automatic test_edge_cases();
    int c;
    goto(t_ready + 167);
    bus.div_half = {8'd255, 8'd0};
    bus.div_load = 2'b11;
    @(negedge clk);
    bus.div_load = 2'b00;
    @(negedge clk);
    bus.ch_en = 2'b11;
    c = cyc;
    push_edges(0, c + 1, 1, 22, 1'b1);
    push_edges(0, c + 26, 4, 251, 1'b1);
    push_edges(1, c + 256, 256, 4, 1'b1);
    goto(c + 21);
    bus.div_half[CW-1:0] = 8'd3;
    bus.div_load = 2'b01;
    @(negedge clk);
    bus.div_load = 2'b00;
    goto(c + 1027);
    n_vec++;
    if (sb0.size() + sb1.size() != 0) begin
      n_err++;
      $display("FAIL edge_events_left: %0d, required 0", sb0.size() + sb1.size());
    end
    n_vec++;
    if (bus.div_clk !== 2'b01) begin
      n_err++;
      $display("FAIL edge_final_level: div_clk=%b, required 01", bus.div_clk);
    end
  endtask

  task automatic test_midrun_rst();
    int t2;
    coh_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.div_clk, bus.rise_tick, bus.fall_tick, bus.init_rst, bus.ready} !== 8'b00_00_00_1_0) begin
      n_err++;
      $display("FAIL midrun_reset_values: clk/rise/fall/init_rst/ready=%b, required 00000010",
               {bus.div_clk, bus.rise_tick, bus.fall_tick, bus.init_rst, bus.ready});
    end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.init_rst, bus.ready, bus.div_clk} !== 4'b1000) begin
        n_err++;
        $display("FAIL midrun_init_hold edge %0d: init_rst/ready/div_clk=%b, required 1000",
                 k, {bus.init_rst, bus.ready, bus.div_clk});
      end
    end
    coh_en = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.init_rst, bus.ready} !== 2'b01) begin
      n_err++;
      $display("FAIL midrun_init_release: init_rst/ready=%b, required 01",
               {bus.init_rst, bus.ready});
    end
    t2 = cyc;
    push_edges(0, t2 + 15, 15, 2, 1'b1);
    push_edges(1, t2 + 15, 15, 2, 1'b1);
    goto(t2 + 31);
    n_vec++;
    if (sb0.size() + sb1.size() != 0) begin
      n_err++;
      $display("FAIL midrun_events_left: %0d, required 0", sb0.size() + sb1.size());
    end
  endtask

  initial begin
    bus.div_half = {8'd14, 8'd14};
    bus.div_load = 2'b00;
    bus.ch_en    = 2'b11;
    test_reset();
    test_default_divide();
    test_reload();
    test_disable();
    test_edge_cases();
    test_midrun_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
